// File: rtl/bin_to_bcd_scan.sv
// Sequential double-dabble converter feeding a scanned four-digit display,
// with leading-zero blanking and an overflow flag for values above 9999.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for load; display register drives the scan
// CONVERT | 14 shift/adjust iterations in progress, busy high
module bin_to_bcd_scan #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  bcd,
    output logic        en,
    output logic [3:0]  digit_sel
);

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);

    state_t      state;
    logic [3:0]  iter_cnt;
    logic [29:0] dabble;
    logic [15:0] disp;
    logic [15:0] refresh_cnt;
    logic [1:0]  digit_idx;

    logic [15:0] adj;
    logic [29:0] dabble_nxt;

    always_comb begin
        adj = dabble[29:14];
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        dabble_nxt = {adj[14:0], dabble[13:0], 1'b0};
    end

    // iter_cnt counts down from 13; the iteration seen at zero is the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            iter_cnt <= 4'd0;
            dabble   <= '0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        if (bin > 14'd9999) begin
                            ovf <= 1'b1;
                        end else begin
                            ovf      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= CONVERT;
                            iter_cnt <= 4'd13;
                            dabble   <= {16'd0, bin};
                        end
                    end
                end
                CONVERT: begin
                    dabble <= dabble_nxt;
                    if (iter_cnt == 4'd0) begin
                        disp  <= dabble_nxt[29:14];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        iter_cnt <= iter_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_MAX) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
        end
    end

    // Outputs depend only on registered state; a digit is lit if it or any
    // higher digit is nonzero, and the ones digit is always lit.
    always_comb begin
        digit_sel = 4'b0001 << digit_idx;
        bcd       = disp[digit_idx*4 +: 4];
        en        = 1'b0;
        case (digit_idx)
            2'd0: en = 1'b1;
            2'd1: en = |disp[15:4];
            2'd2: en = |disp[15:8];
            2'd3: en = |disp[15:12];
            default: en = 1'b0;
        endcase
        if (ovf)
            en = 1'b0;
    end

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Self-checking bench for bin_to_bcd_scan with a four-cycle digit refresh;
// expected display words are queued at load time and consumed when busy drops.
module tb_bin_to_bcd_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic        ovf;
    logic [3:0]  bcd;
    logic        en;
    logic [3:0]  digit_sel;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    bin_to_bcd_scan #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .bin(bin),
        .busy(busy),
        .ovf(ovf),
        .bcd(bcd),
        .en(en),
        .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One-cycle load pulse; expected display word queued when it should convert.
    task automatic do_load(input int v, input bit push);
        bin  = 14'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
        if (push)
            exp_q.push_back(to_bcd(v));
    endtask

    // Called in busy cycle 1; counts busy cycles and returns the queued result.
    task automatic wait_done(output logic [15:0] disp);
        int n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        chk("busy_len", n, 14);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            disp = '0;
        end else begin
            disp = exp_q.pop_front();
        end
    endtask

    task automatic scan_check(input logic [15:0] disp, input logic [3:0] en_mask);
        int n = 0;
        while (digit_sel !== 4'b1000 && n < 32) begin
            n++;
            tick();
        end
        while (digit_sel !== 4'b0001 && n < 32) begin
            n++;
            tick();
        end
        if (n >= 32)
            chk("scan_align_timeout", n, 0);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk("digit_sel", digit_sel, 32'(4'b0001 << d));
                chk("bcd", bcd, 32'(disp[d*4 +: 4]));
                chk("en", en, 32'(en_mask[d]));
                tick();
            end
        end
    endtask

    initial begin
        logic [15:0] disp;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sel", digit_sel, 4'b0001);
        chk("rst_bcd", bcd, 0);
        chk("rst_en", en, 1);
        rst = 1'b0;

        // Basic conversion
        do_load(1234, 1);
        chk("busy_after_load", busy, 1);
        wait_done(disp);
        chk("busy_low", busy, 0);
        scan_check(disp, 4'b1111);

        // Leading-zero blanking
        do_load(7, 1);
        wait_done(disp);
        scan_check(disp, 4'b0001);
        do_load(0, 1);
        wait_done(disp);
        scan_check(disp, 4'b0001);

        // Overflow, then recovery
        do_load(10000, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_busy", busy, 0);
        tick();
        chk("ovf_busy_hold", busy, 0);
        chk("ovf_hold", ovf, 1);
        scan_check(16'h0000, 4'b0000);
        do_load(9999, 1);
        chk("ovf_clear", ovf, 0);
        chk("ovf_load_busy", busy, 1);
        wait_done(disp);
        scan_check(disp, 4'b1111);

        // Loads while busy are ignored (busy cycle 1 and busy cycle 14)
        do_load(1234, 1);
        chk("lb_busy1", busy, 1);
        do_load(42, 0);
        for (int i = 2; i < 14; i++) begin
            chk("lb_busy_mid", busy, 1);
            tick();
        end
        chk("lb_busy14", busy, 1);
        do_load(42, 0);
        chk("lb_busy_fall", busy, 0);
        tick();
        chk("lb_no_restart", busy, 0);
        disp = exp_q.size() > 0 ? exp_q.pop_front() : 16'hffff;
        chk("lb_scoreboard", disp, 16'h1234);
        scan_check(disp, 4'b1111);

        // Reset mid-conversion: 5678 must never appear
        do_load(5678, 0);
        for (int i = 1; i < 7; i++)
            tick();
        chk("mid_busy7", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_sel", digit_sel, 4'b0001);
        chk("mid_bcd", bcd, 0);
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0)
                chk("mid_busy_stays_low", busy, 0);
            tick();
        end
        scan_check(16'h0000, 4'b0001);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_scan.md
BIN_TO_BCD_SCAN -- requirements
Module: bin_to_bcd_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 1000, giving the clock cycles each digit is held during scanning (legal range 1 to 65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port load, input, 1, a request to start converting bin.
REQ-005 The block SHALL have port bin, input, 14, an unsigned binary value; the legal display range is 0..9999.
REQ-006 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 The block SHALL have port ovf, output, 1, high when the last accepted load had bin > 9999.
REQ-008 The block SHALL have port bcd, output, 4, the BCD digit currently scanned; it feeds the downstream 7-segment decoder's bcd input.
REQ-009 The block SHALL have port en, output, 1, the enable for the current digit; it feeds the decoder's en input.
REQ-010 The block SHALL have port digit_sel, output, 4, a one-hot active-high digit strobe: bit0 = ones, bit3 = thousands.

Function
REQ-011 The block SHALL accept a load only when load=1 and busy=0; a load while busy=1, including the final conversion cycle, SHALL be ignored.
REQ-012 On an accepted load with bin <= 9999, the block SHALL capture bin, clear ovf, and assert busy from the next cycle.
REQ-013 The conversion SHALL be a sequential double-dabble with states IDLE and CONVERT and a 4-bit iteration counter.
REQ-014 Each CONVERT iteration SHALL add 3 to every BCD nibble >= 5, then shift the {bcd, binary} register left by 1.
REQ-015 CONVERT SHALL last exactly 14 cycles, so busy is high for exactly 14 cycles.
REQ-016 At the end of the 14th CONVERT cycle, the block SHALL write the four BCD digits to the display register and return to IDLE; busy SHALL be 0 and the new digits visible in the following cycle.
REQ-017 On an accepted load with bin > 9999, the block SHALL set ovf=1, leave busy at 0, and leave the display register unchanged.
REQ-018 ovf SHALL hold until the next accepted load or reset.
REQ-019 The scan SHALL continue during conversion, displaying the previous display register contents.
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-021 With REFRESH_DIV=1, the digit index SHALL advance every cycle.
REQ-022 digit_sel SHALL be the one-hot decode of the digit index.
REQ-023 bcd SHALL equal the display register nibble selected by the digit index.
REQ-024 bcd, en and digit_sel SHALL be combinational decodes of registered state only, with no path from load or bin.
REQ-025 en SHALL implement leading-zero blanking: en=0 for any digit above the most significant nonzero digit; digit 0 is always enabled (value 0 shows one "0").
REQ-026 While ovf=1, en SHALL be 0 for all digits; digit_sel SHALL keep scanning.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE, abort any conversion, and set busy=0, ovf=0, display register=0, digit index=0, refresh counter=0, and iteration counter=0.
REQ-028 In the cycle after reset, outputs SHALL be bcd=4'h0, en=1, digit_sel=4'b0001, busy=0, ovf=0.
REQ-029 rst SHALL take priority over load in the same cycle.

Verification
REQ-030 The bench SHALL check reset: assert rst 2 cycles -> busy=0, ovf=0, digit_sel=0001, bcd=0, en=1.
REQ-031 The bench SHALL check conversion with REFRESH_DIV=4: load bin=1234 -> busy high exactly 14 cycles; then the scan gives bcd 4,3,2,1 for digit_sel 0001,0010,0100,1000, each held 4 cycles, all en=1.
REQ-032 The bench SHALL check blanking: load bin=7 -> digit0 bcd=7 en=1, digits 1-3 en=0; load bin=0 -> digit0 bcd=0 en=1, others en=0.
REQ-033 The bench SHALL check overflow: load bin=10000 -> ovf=1, busy stays 0, en=0 on all digits; then load bin=9999 -> ovf=0 at acceptance, and after 14 busy cycles all four digits show 9 with en=1.
REQ-034 The bench SHALL check load while busy: load 1234, then load 42 on busy cycles 1 and 14 -> both ignored, display shows 1234, busy falls once.
REQ-035 The bench SHALL check reset mid-conversion: assert rst on busy cycle 7 of a 5678 load -> next cycle busy=0, display=0000, digit_sel=0001; no later update to 5678.
